// File: rtl/dcache_refill_unit.sv
// dcache_refill_unit: miss-handling refill engine for the data cache.
// Accepts one block miss, issues a block-aligned memory read, collects
// block_size 64-bit beats in ascending order, then performs a single
// full-block write into the cache array. In that same cycle it returns the
// requested double word to the core.
//
// Ports:
//   clock, reset        - single clock, synchronous active-high reset
//   miss_*              - miss request from the load/store path (valid/ready)
//   mem_req_*           - block read request to memory (valid/ready)
//   mem_resp_*          - response beats, double word 0 first
//   write_*             - cache array write port (strobe, line, block, tag, mask)
//   refill_done/_data   - completion pulse and requested double word
//   busy                - engine is not idle
module dcache_refill_unit #(
    parameter  int unsigned double_word_offset_width = 3,
    parameter  int unsigned line_width               = 6,
    localparam int unsigned block_size               = 1 << double_word_offset_width,
    localparam int unsigned tag_width                = 32 - double_word_offset_width - 3 - line_width
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      miss_valid,
    output logic                      miss_ready,
    input  logic [31:0]               miss_address,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [31:0]               mem_req_address,
    input  logic                      mem_resp_valid,
    input  logic [63:0]               mem_resp_data,
    output logic                      write_in,
    output logic [line_width-1:0]     write_line_index,
    output logic [64*block_size-1:0]  write_block,
    output logic [tag_width-1:0]      write_tag,
    output logic [block_size-1:0]     write_mask,
    output logic                      refill_done,
    output logic [63:0]               refill_data,
    output logic                      busy
);

    localparam int unsigned CNT_W    = double_word_offset_width;
    localparam int unsigned LINE_LSB = double_word_offset_width + 3;
    localparam int unsigned TAG_LSB  = LINE_LSB + line_width;
    localparam int unsigned BLOCK_W  = 64 * block_size;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RECV,
        WRITE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   counter_q, counter_d;
    logic [31:3]        addr_q, addr_d;
    logic [BLOCK_W-1:0] buf_q, buf_d;

    // Byte-within-double-word bits never influence a refill.
    logic unused_byte_bits;
    assign unused_byte_bits = ^miss_address[2:0];

    // State and beat counter are reset; address and buffer are don't-care until written.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            counter_q <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
        end
    end

    always_ff @(posedge clock) begin
        addr_q <= addr_d;
        buf_q  <= buf_d;
    end

    // Next-state, datapath updates and output decode.
    always_comb begin
        state_d          = state_q;
        counter_d        = counter_q;
        addr_d           = addr_q;
        buf_d            = buf_q;
        miss_ready       = 1'b0;
        mem_req_valid    = 1'b0;
        write_in         = 1'b0;
        write_mask       = '0;
        refill_done      = 1'b0;
        busy             = (state_q != IDLE);
        mem_req_address  = {addr_q[31:LINE_LSB], {LINE_LSB{1'b0}}};
        write_line_index = addr_q[TAG_LSB-1:LINE_LSB];
        write_tag        = addr_q[31:TAG_LSB];
        write_block      = buf_q;
        refill_data      = buf_q[{addr_q[LINE_LSB-1:3], 6'b0} +: 64];

        unique case (state_q)
            IDLE: begin
                // Ready is masked by reset so no miss can be taken while resetting.
                miss_ready = ~reset;
                if (miss_valid && !reset) begin
                    addr_d  = miss_address[31:3];
                    state_d = REQ;
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    counter_d = '0;
                    state_d   = RECV;
                end
            end
            RECV: begin
                if (mem_resp_valid) begin
                    buf_d[{counter_q, 6'b0} +: 64] = mem_resp_data;
                    counter_d = counter_q + CNT_W'(1);
                    if (counter_q == CNT_W'(block_size - 1)) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                write_in    = 1'b1;
                write_mask  = '1;
                refill_done = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_refill_unit.sv
// Directed bench for dcache_refill_unit with default parameters.
// Inputs are driven and outputs are checked on the falling clock edge.
module tb_dcache_refill_unit;

    logic         clock = 1'b0;
    logic         reset;
    logic         miss_valid;
    logic         miss_ready;
    logic [31:0]  miss_address;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [31:0]  mem_req_address;
    logic         mem_resp_valid;
    logic [63:0]  mem_resp_data;
    logic         write_in;
    logic [5:0]   write_line_index;
    logic [511:0] write_block;
    logic [19:0]  write_tag;
    logic [7:0]   write_mask;
    logic         refill_done;
    logic [63:0]  refill_data;
    logic         busy;

    int n_pass   = 0;
    int n_total  = 0;
    int wr_cnt   = 0;
    int done_cnt = 0;

    always #5 clock = ~clock;

    dcache_refill_unit dut (
        .clock            (clock),
        .reset            (reset),
        .miss_valid       (miss_valid),
        .miss_ready       (miss_ready),
        .miss_address     (miss_address),
        .mem_req_valid    (mem_req_valid),
        .mem_req_ready    (mem_req_ready),
        .mem_req_address  (mem_req_address),
        .mem_resp_valid   (mem_resp_valid),
        .mem_resp_data    (mem_resp_data),
        .write_in         (write_in),
        .write_line_index (write_line_index),
        .write_block      (write_block),
        .write_tag        (write_tag),
        .write_mask       (write_mask),
        .refill_done      (refill_done),
        .refill_data      (refill_data),
        .busy             (busy)
    );

    // Count array writes and completion pulses over the whole run.
    always @(posedge clock) begin
        if (write_in === 1'b1)    wr_cnt++;
        if (refill_done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    // One complete refill starting from IDLE at a falling edge.
    task automatic run_refill(input logic [31:0] addr, input logic [31:0] exp_req,
                              input logic [5:0] exp_line, input logic [19:0] exp_tag,
                              input int off, input logic [63:0] base,
                              input int stall, input bit inject, input bit gapped,
                              input bit hold, input logic [31:0] next_addr);
        logic [511:0] blk;
        int cyc;
        for (int j = 0; j < 8; j++) blk[64*j +: 64] = base + 64'(j);
        check("idle_ready", miss_ready, 1);
        miss_valid     = 1'b1;
        miss_address   = addr;
        mem_req_ready  = (stall == 0);
        mem_resp_valid = inject;
        mem_resp_data  = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        cyc = 1;
        if (hold) miss_address = next_addr;
        else      miss_valid   = 1'b0;
        check("req_valid", mem_req_valid, 1);
        check("req_addr", mem_req_address, exp_req);
        for (int k = 0; k < stall; k++) begin
            tick();
            cyc++;
            check("req_held_valid", mem_req_valid, 1);
            check("req_held_addr", mem_req_address, exp_req);
            check("req_held_ready", miss_ready, 0);
        end
        mem_req_ready = 1'b1;
        tick();
        cyc++;
        for (int i = 0; i < 8; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = base + 64'(i);
            tick();
            cyc++;
            if (i < 7) begin
                check("no_early_write", write_in, 0);
                if (gapped) begin
                    mem_resp_valid = 1'b0;
                    tick();
                    cyc++;
                    check("gap_no_write", write_in, 0);
                end
            end
        end
        mem_resp_valid = 1'b0;
        check("write_in", write_in, 1);
        check("refill_done", refill_done, 1);
        check("write_mask", write_mask, 8'hFF);
        check("write_line", write_line_index, exp_line);
        check("write_tag", write_tag, exp_tag);
        check("write_block", write_block, blk);
        check("refill_data", refill_data, base + 64'(off));
        check("write_miss_ready", miss_ready, 0);
        if (stall == 0 && !gapped) check("latency", cyc, 10);
        tick();
        check("post_write_in", write_in, 0);
        check("post_done", refill_done, 0);
        check("post_ready", miss_ready, 1);
        check("post_busy", busy, 0);
    endtask

    initial begin
        logic [511:0] gblk;
        reset          = 1'b1;
        miss_valid     = 1'b1;
        miss_address   = 32'h0000_1A48;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        tick();
        tick();
        check("rst_miss_ready", miss_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_write_in", write_in, 0);
        check("rst_done", refill_done, 0);
        check("rst_mask", write_mask, 8'h00);
        miss_valid = 1'b0;
        reset      = 1'b0;
        tick();
        check("idle_miss_ready", miss_ready, 1);
        check("idle_busy", busy, 0);

        // Basic refill
        run_refill(32'h0000_1A48, 32'h0000_1A40, 6'h29, 20'h00001, 1,
                   64'h1000, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("basic_wr_cnt", wr_cnt, 1);
        check("basic_done_cnt", done_cnt, 1);

        // Request backpressure with beats injected during REQ
        run_refill(32'h0004_0E58, 32'h0004_0E40, 6'h39, 20'h00040, 3,
                   64'h5555_0000_0000_0100, 5, 1'b1, 1'b0, 1'b0, 32'h0);

        // Gapped beats, then a stray beat in IDLE
        run_refill(32'h0000_3010, 32'h0000_3000, 6'h00, 20'h00003, 2,
                   64'hA0A0_0000_0000_0010, 0, 1'b0, 1'b1, 1'b0, 32'h0);
        for (int j = 0; j < 8; j++) gblk[64*j +: 64] = 64'hA0A0_0000_0000_0010 + 64'(j);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'h0BAD_0BAD_0BAD_0BAD;
        tick();
        mem_resp_valid = 1'b0;
        check("stray_busy", busy, 0);
        check("stray_block", write_block, gblk);
        tick();
        check("stray_wr_cnt", wr_cnt, 3);

        // Second miss held off during a refill, accepted right after WRITE
        run_refill(32'h8000_0FF0, 32'h8000_0FC0, 6'h3F, 20'h80000, 6,
                   64'hC000_0000_0000_0000, 0, 1'b0, 1'b0, 1'b1, 32'h1234_5678);
        run_refill(32'h1234_5678, 32'h1234_5640, 6'h19, 20'h12345, 7,
                   64'hD000_0000_0000_0040, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("hold_wr_cnt", wr_cnt, 5);

        // Reset in the middle of collecting beats
        miss_valid    = 1'b1;
        miss_address  = 32'h0000_1A48;
        mem_req_ready = 1'b1;
        tick();
        miss_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 64'hEEEE_0000_0000_0000 + 64'(i);
            tick();
        end
        check("pre_rst_busy", busy, 1);
        mem_resp_valid = 1'b0;
        reset          = 1'b1;
        tick();
        check("midrst_busy", busy, 0);
        check("midrst_ready", miss_ready, 0);
        check("midrst_write_in", write_in, 0);
        reset = 1'b0;
        tick();
        check("midrst_ready_after", miss_ready, 1);
        check("midrst_done", refill_done, 0);
        tick();
        check("midrst_wr_cnt", wr_cnt, 5);
        check("midrst_done_cnt", done_cnt, 5);
        run_refill(32'h0000_00C8, 32'h0000_00C0, 6'h03, 20'h00000, 1,
                   64'h7700_0000_0000_0000, 0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Offset selection at both ends of the block
        run_refill(32'h0000_2000, 32'h0000_2000, 6'h00, 20'h00002, 0,
                   64'h0123_4567_0000_0000, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        run_refill(32'h0000_2038, 32'h0000_2000, 6'h00, 20'h00002, 7,
                   64'h89AB_CDEF_0000_0000, 0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        check("final_wr_cnt", wr_cnt, 8);
        check("final_done_cnt", done_cnt, 8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dcache_refill_unit.md
Name: dcache_refill_unit

Overview:
Miss-handling refill engine for the data cache; the writer that fills the dcache register array.
- Accepts one block-miss request from the load/store path.
- Issues a block-aligned read request to memory and collects block_size 64-bit beats in ascending order.
- Drives a single full-block write (line index, block, tag, mask, write strobe) into the cache array.
- Returns the requested double word to the core on the same cycle.

Parameters:
- double_word_offset_width, 3, log2 of double words per block; block_size = 1 << double_word_offset_width.
- line_width, 6, log2 of cache lines; derived tag_width = 32 - double_word_offset_width - 3 - line_width (20 with defaults).

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- miss_valid  in  1  core presents a miss.
- miss_ready  out  1  engine can accept a miss.
- miss_address  in  32  byte address that missed.
- mem_req_valid  out  1  block read request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_address  out  32  block-aligned address: low double_word_offset_width+3 bits are zero.
- mem_resp_valid  in  1  one response beat valid.
- mem_resp_data  in  64  response beat, double word 0 first.
- write_in  out  1  cache array write strobe.
- write_line_index  out  line_width  target line.
- write_block  out  64*block_size  assembled block; double word j is at bits [64*j +: 64].
- write_tag  out  tag_width  tag to install.
- write_mask  out  block_size  per-double-word write enable.
- refill_done  out  1  one-cycle pulse; refill complete.
- refill_data  out  64  double word selected by miss_address[double_word_offset_width+2:3].
- busy  out  1  high in any state other than IDLE.

Behaviour:
- State machine: IDLE, REQ, RECV, WRITE. Reset forces IDLE, beat counter 0, buffer contents don't-care.
- Output values under reset and in IDLE:
  - miss_ready = 1 only in IDLE with reset low; it is 0 while reset is high.
  - mem_req_valid = 0, write_in = 0, refill_done = 0, busy = 0, write_mask = 0.
- IDLE:
  - On miss_valid && miss_ready, latch miss_address and go to REQ.
  - miss_address is sampled only on this handshake.
- REQ:
  - mem_req_valid = 1.
  - mem_req_address = {latched tag, latched line, zeros}, held stable until the handshake.
  - On mem_req_ready, go to RECV with beat counter = 0.
  - A mem_resp_valid seen in REQ, including the handshake cycle, is ignored.
- RECV:
  - Each cycle with mem_resp_valid, store mem_resp_data in buffer slot [counter] and increment the counter.
  - Gaps (mem_resp_valid low) are allowed, with no timeout.
  - The beat accepted at counter == block_size-1 moves the FSM to WRITE. The counter wraps to 0; no extra beat is stored.
- WRITE (exactly one cycle):
  - write_in = 1 and write_mask = all ones.
  - write_line_index and write_tag come from the latched address; write_block = buffer.
  - refill_done = 1 and refill_data = buffer[latched offset].
  - Next state is IDLE. miss_ready returns to 1 on the following cycle, so there is no back-to-back accept in WRITE.
- Outside WRITE:
  - write_in and refill_done are 0.
  - write_line_index, write_tag and write_block may show latched or buffer values but carry no meaning.
- mem_resp_valid outside RECV is ignored; it never corrupts the buffer.
- Latency, miss accept to refill_done with mem_req_ready already high and beats back-to-back: REQ lasts 1 cycle, RECV lasts block_size cycles, WRITE lasts 1 cycle. The total is block_size+2 cycles after the accept cycle (10 with defaults).
- Reset asserted in any state:
  - Next cycle is IDLE.
  - A partially collected block is discarded; no write_in and no refill_done occur for it.
  - An outstanding memory request is abandoned; the memory side must be reset by the same signal.
- Single outstanding miss only; miss_valid while busy is held off by miss_ready = 0.

Test Plan:
- Basic refill:
  - Stimulus: reset, then miss at 0x0000_1A48 with mem_req_ready=1 and 8 back-to-back beats of value 0x1000+i.
  - Response: mem_req_address=0x0000_1A40; one write_in with line 0x29, tag 0x00001 and write_mask 0xFF; write_block slot i = 0x1000+i; refill_data = 0x1001.
  - Timing: refill_done 10 cycles after the accept.
- Request backpressure:
  - Stimulus: hold mem_req_ready=0 for 5 cycles.
  - Response: mem_req_valid stays 1, address stable, no state advance; a beat injected during REQ is ignored (buffer slot 0 takes the first RECV beat).
- Gapped beats:
  - Stimulus: alternate mem_resp_valid 1/0 across 8 beats.
  - Response: slots fill in order; write_in arrives exactly one cycle after the 8th beat; a 9th stray beat in IDLE has no effect.
- Held-off second miss:
  - Stimulus: hold miss_valid high with a second address during a refill.
  - Response: miss_ready=0 until the cycle after WRITE; the second miss is accepted then and mem_req_address reflects the new address.
- Mid-operation reset:
  - Stimulus: assert reset after 4 beats.
  - Response: IDLE next cycle, no write_in or refill_done, miss_ready=1 once reset drops; a fresh refill then completes correctly.
- Offset selection:
  - Stimulus: misses at offsets 0 and 7 (addresses 0x...00 and 0x...38).
  - Response: refill_data equals beat 0 and beat 7 respectively.
